ntt_seq_ctrl: RTL
=================

Name: ntt_seq_ctrl

Overview:
- Synthesizable command sequencer that drives an NTTN core through its serial protocol: twiddle load, coefficient load, NTT/INTT start, wait for done, result capture.
- Replaces hand-timed bench sequencing so NTTN can be used on-chip behind a host command port and a source RAM.
- Parametrised in ring/PE depth, data width, gap length and timeout; adds a done-timeout, a busy/error status and a result index stream.

Parameters:
- DATA_SIZE, 64, word width of din/dout/src_rdata.
- RING_DEPTH, 10, log2 ring size N; N = 1<<RING_DEPTH.
- PE_DEPTH, 3, log2 PE count; twiddle count TW = (((1<<(RING_DEPTH-PE_DEPTH))-1)+PE_DEPTH)<<PE_DEPTH.
- GAP, 5, idle cycles between end of a load stream and the next pulse (≥1).
- TO_W, 24, width of done-timeout counter; timeout = (1<<TO_W)-1 cycles.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_op  in  2  0=LOAD_TW, 1=NTT, 2=INTT, 3=reserved (rejected).
- cmd_ready  out  1  high only in IDLE.
- cmd_done  out  1  one-cycle pulse at command completion.
- cmd_err  out  1  valid with cmd_done: 1=timeout or reserved op.
- busy  out  1  high in any state other than IDLE.
- src_addr  out  RING_DEPTH+2  source RAM read address (1-cycle read latency).
- src_rdata  in  DATA_SIZE  source RAM data.
- nttn_load_w, nttn_load_data, nttn_start, nttn_start_intt  out  1  NTTN control pulses.
- nttn_din  out  DATA_SIZE  NTTN data input.
- nttn_done  in  1  NTTN done.
- nttn_dout  in  DATA_SIZE  NTTN data output.
- res_valid  out  1  result word valid.
- res_data  out  DATA_SIZE  result word.
- res_idx  out  RING_DEPTH  result index 0..N-1.

Behaviour:
- Reset: state IDLE; all outputs 0 except cmd_ready=1; counters cleared. Reset mid-operation aborts immediately; no cmd_done issued.
- Handshake: command accepted on cmd_valid&cmd_ready. Reserved op: cmd_done=cmd_err=1 on next cycle, return to IDLE.
- States: IDLE, PULSE, STREAM, GAP_W, START, WAIT_DONE, CAPTURE, FIN.
- PULSE (1 cycle): assert nttn_load_w (LOAD_TW) or nttn_load_data (NTT/INTT); src_addr=0.
- STREAM: L = 2*TW+2 words (LOAD_TW: w, winv, then two param words) or N words (NTT/INTT). Cycle j after PULSE (j=0..L-1): nttn_din=src_rdata (data for address j), src_addr=j+1. nttn_din=0 outside STREAM. src_addr=0 when not streaming.
- GAP_W: GAP cycles idle. LOAD_TW then → FIN; NTT/INTT → START.
- START (1 cycle): nttn_start (NTT) or nttn_start_intt (INTT); timeout counter cleared.
- WAIT_DONE: count cycles; on nttn_done=1 → CAPTURE (next cycle). Counter saturating at max → cmd_err=1, → FIN.
- CAPTURE: N consecutive cycles starting cycle after done sampled high; res_valid=1, res_data=nttn_dout (registered: appears one cycle after sampling), res_idx=0..N-1. No backpressure; consumer must accept every cycle.
- FIN: cmd_done pulse (1 cycle), cmd_err held valid that cycle, → IDLE.
- nttn_done during STREAM/GAP_W/START ignored. cmd_valid while busy ignored (not queued).
- Latency, NTT: 1 (accept) + 1 + N + GAP + 1 + t_done + 1 + N + 1 cycles to cmd_done.

Test Plan:
- RING_DEPTH=4, PE_DEPTH=1 (N=16, TW=16); LOAD_TW with RAM[k]=k → nttn_load_w pulse, then 34 cycles nttn_din=0..33, 5 idle, cmd_done=1, cmd_err=0.
- NTT with model NTTN asserting done 40 cycles after start, dout=0x100+i → nttn_start single pulse after 16 words + 5 gap; 16 res_valid words 0x100..0x10F, res_idx 0..15, then cmd_done.
- INTT same flow → nttn_start_intt pulses, nttn_start stays 0; results captured identically.
- TO_W=6, NTT with done never asserted → cmd_done with cmd_err=1 after 63 wait cycles; no res_valid.
- cmd_op=3 → cmd_done & cmd_err next cycle, no NTTN pulses; cmd_valid held high while busy → only one command executed.
- reset asserted mid-STREAM (word 7) → next cycle all outputs 0, cmd_ready=1; fresh NTT completes correctly.

Source files
------------

// File: rtl/ntt_seq_ctrl.sv
// ntt_seq_ctrl: command sequencer for an NTTN core.
// It runs the NTTN serial protocol: a load pulse, streaming words from a source
// RAM, an idle gap, an NTT/INTT start, a wait for done with a timeout, and
// capture of the N result words.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   cmd_valid/cmd_op/cmd_ready host command handshake (op 0=LOAD_TW,1=NTT,2=INTT,3=reserved)
//   cmd_done/cmd_err           completion pulse and error flag (timeout or reserved op)
//   busy                       high whenever the sequencer is not idle
//   src_addr/src_rdata         source RAM read port (1-cycle read latency)
//   nttn_load_w/_load_data     NTTN load pulses
//   nttn_start/_start_intt     NTTN start pulses
//   nttn_din/nttn_done/nttn_dout  NTTN data and done
//   res_valid/res_data/res_idx result word stream, one word per cycle, no backpressure
module ntt_seq_ctrl #(
  parameter int unsigned DATA_SIZE  = 64,
  parameter int unsigned RING_DEPTH = 10,
  parameter int unsigned PE_DEPTH   = 3,
  parameter int unsigned GAP        = 5,
  parameter int unsigned TO_W       = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  input  logic [1:0]              cmd_op,
  output logic                    cmd_ready,
  output logic                    cmd_done,
  output logic                    cmd_err,
  output logic                    busy,
  output logic [RING_DEPTH+1:0]   src_addr,
  input  logic [DATA_SIZE-1:0]    src_rdata,
  output logic                    nttn_load_w,
  output logic                    nttn_load_data,
  output logic                    nttn_start,
  output logic                    nttn_start_intt,
  output logic [DATA_SIZE-1:0]    nttn_din,
  input  logic                    nttn_done,
  input  logic [DATA_SIZE-1:0]    nttn_dout,
  output logic                    res_valid,
  output logic [DATA_SIZE-1:0]    res_data,
  output logic [RING_DEPTH-1:0]   res_idx
);

  localparam int unsigned N     = 32'd1 << RING_DEPTH;
  localparam int unsigned TW    = (((32'd1 << (RING_DEPTH - PE_DEPTH)) - 32'd1) + PE_DEPTH) << PE_DEPTH;
  localparam int unsigned TW_L  = 2 * TW + 2;
  localparam int unsigned CNT_W = RING_DEPTH + 2;

  localparam logic [CNT_W-1:0] TW_LAST  = CNT_W'(TW_L - 1);
  localparam logic [CNT_W-1:0] N_LAST   = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = {{(TO_W-1){1'b1}}, 1'b0};

  localparam logic [1:0] OP_TW   = 2'd0;
  localparam logic [1:0] OP_NTT  = 2'd1;
  localparam logic [1:0] OP_INTT = 2'd2;
  localparam logic [1:0] OP_RSV  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PULSE, ST_STREAM, ST_GAP_W, ST_START, ST_WAIT_DONE, ST_CAPTURE, ST_FIN
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TO_W-1:0]      to_q, to_d;
  logic [1:0]           op_q, op_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     stream_last;

  logic                 cmd_ready_q, cmd_ready_d;
  logic                 cmd_done_q, cmd_done_d;
  logic                 cmd_err_q, cmd_err_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     src_addr_q, src_addr_d;
  logic                 load_w_q, load_w_d;
  logic                 load_data_q, load_data_d;
  logic                 start_q, start_d;
  logic                 start_intt_q, start_intt_d;
  logic                 res_valid_q, res_valid_d;
  logic [DATA_SIZE-1:0] res_data_q, res_data_d;
  logic [RING_DEPTH-1:0] res_idx_q, res_idx_d;

  assign stream_last = (op_q == OP_TW) ? TW_LAST : N_LAST;

  // Next state and registered outputs; outputs are decoded from the next state
  // so they line up with the cycle the sequencer is in that state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    op_d    = op_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        err_d = 1'b0;
        if (cmd_valid) begin
          op_d = cmd_op;
          if (cmd_op == OP_RSV) begin
            err_d   = 1'b1;
            state_d = ST_FIN;
          end else begin
            state_d = ST_PULSE;
          end
        end
      end
      ST_PULSE: begin
        cnt_d   = '0;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (cnt_q == stream_last) begin
          cnt_d   = '0;
          state_d = ST_GAP_W;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP_W: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = (op_q == OP_TW) ? ST_FIN : ST_START;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_START: begin
        to_d    = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // done wins over a timeout landing in the same cycle
        if (nttn_done) begin
          cnt_d   = '0;
          state_d = ST_CAPTURE;
        end else begin
          to_d = to_q + TO_W'(1);
          if (to_q == TO_LAST) begin
            err_d   = 1'b1;
            state_d = ST_FIN;
          end
        end
      end
      ST_CAPTURE: begin
        if (cnt_q == N_LAST) begin
          cnt_d   = '0;
          state_d = ST_FIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d  = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    cmd_done_d   = (state_d == ST_FIN);
    cmd_err_d    = (state_d == ST_FIN) && err_d;
    load_w_d     = (state_d == ST_PULSE) && (op_d == OP_TW);
    load_data_d  = (state_d == ST_PULSE) && (op_d != OP_TW);
    start_d      = (state_d == ST_START) && (op_d == OP_NTT);
    start_intt_d = (state_d == ST_START) && (op_d == OP_INTT);
    // address runs one ahead of the word being forwarded to cover RAM latency
    src_addr_d   = (state_d == ST_STREAM) ? cnt_d + CNT_W'(1) : '0;
    res_valid_d  = (state_d == ST_CAPTURE);
    res_data_d   = (state_d == ST_CAPTURE) ? nttn_dout : '0;
    res_idx_d    = (state_d == ST_CAPTURE) ? cnt_d[RING_DEPTH-1:0] : '0;
  end

  // State, counters and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      to_q         <= '0;
      op_q         <= '0;
      err_q        <= 1'b0;
      cmd_ready_q  <= 1'b1;
      cmd_done_q   <= 1'b0;
      cmd_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      src_addr_q   <= '0;
      load_w_q     <= 1'b0;
      load_data_q  <= 1'b0;
      start_q      <= 1'b0;
      start_intt_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      to_q         <= to_d;
      op_q         <= op_d;
      err_q        <= err_d;
      cmd_ready_q  <= cmd_ready_d;
      cmd_done_q   <= cmd_done_d;
      cmd_err_q    <= cmd_err_d;
      busy_q       <= busy_d;
      src_addr_q   <= src_addr_d;
      load_w_q     <= load_w_d;
      load_data_q  <= load_data_d;
      start_q      <= start_d;
      start_intt_q <= start_intt_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_idx_q    <= res_idx_d;
    end
  end

  // RAM read data is already registered, so the stream is a gated pass-through
  assign nttn_din = (state_q == ST_STREAM) ? src_rdata : '0;

  assign cmd_ready       = cmd_ready_q;
  assign cmd_done        = cmd_done_q;
  assign cmd_err         = cmd_err_q;
  assign busy            = busy_q;
  assign src_addr        = src_addr_q;
  assign nttn_load_w     = load_w_q;
  assign nttn_load_data  = load_data_q;
  assign nttn_start      = start_q;
  assign nttn_start_intt = start_intt_q;
  assign res_valid       = res_valid_q;
  assign res_data        = res_data_q;
  assign res_idx         = res_idx_q;

endmodule
